// File: rtl/i_decode_pkg.sv
// Shared decode-stage definitions.
// Contents: opcode constants, control-bundle widths, NOP encoding and the
// main-control truth table. Execute, mem and wb stages import the same
// package so that every stage agrees on the control encodings.
package i_decode_pkg;

    localparam int DATA_W = 32;

    // Control bundle widths
    localparam int WB_W = 2;   // {RegWrite, MemtoReg}
    localparam int M_W  = 3;   // {Branch, MemRead, MemWrite}
    localparam int EX_W = 4;   // {RegDst, ALUOp[1:0], ALUSrc}

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // All-zero word is "sll $0,$0,0", the canonical MIPS NOP
    localparam logic [DATA_W-1:0] NOP_ENC = 32'h0000_0000;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctl_t;

    // Main control: any opcode not listed decodes to an all-zero bubble
    function automatic ctl_t decode_ctl(input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin c.ex = 4'b1100; c.m = 3'b000; c.wb = 2'b10; end
            OP_LW:    begin c.ex = 4'b0001; c.m = 3'b010; c.wb = 2'b11; end
            OP_SW:    begin c.ex = 4'b0001; c.m = 3'b001; c.wb = 2'b00; end
            OP_BEQ:   begin c.ex = 4'b0010; c.m = 3'b100; c.wb = 2'b00; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i_decode_if.sv
// Bundle of fetch inputs, hazard controls, write-back port and ID/EX outputs
// of the decode stage. The slave modport is the decode stage itself; the
// master modport is whatever drives it (pipeline top or testbench).
interface i_decode_if #(
    parameter int ADDR_W = 5
);
    import i_decode_pkg::*;

    logic [DATA_W-1:0] instr_in;
    logic [DATA_W-1:0] npc_in;
    logic              stall;
    logic              flush;
    logic              wb_reg_write;
    logic [ADDR_W-1:0] wb_write_reg;
    logic [DATA_W-1:0] wb_write_data;

    logic [DATA_W-1:0] npc_out;
    logic [DATA_W-1:0] rd1_out;
    logic [DATA_W-1:0] rd2_out;
    logic [DATA_W-1:0] sext_out;
    logic [4:0]        rt_out;
    logic [4:0]        rd_out;
    logic [WB_W-1:0]   wb_ctl;
    logic [M_W-1:0]    m_ctl;
    logic [EX_W-1:0]   ex_ctl;

    modport slave (
        input  instr_in, npc_in, stall, flush,
               wb_reg_write, wb_write_reg, wb_write_data,
        output npc_out, rd1_out, rd2_out, sext_out, rt_out, rd_out,
               wb_ctl, m_ctl, ex_ctl
    );

    modport master (
        output instr_in, npc_in, stall, flush,
               wb_reg_write, wb_write_reg, wb_write_data,
        input  npc_out, rd1_out, rd2_out, sext_out, rt_out, rd_out,
               wb_ctl, m_ctl, ex_ctl
    );

endinterface

// File: rtl/i_decode_reg_file.sv
// 2-read / 1-write register file.
// Reads are combinational, register 0 always reads zero and ignores writes,
// and a write in the same cycle as a read of the same register is forwarded
// so decode sees the value write-back is committing this cycle.
module i_decode_reg_file
    import i_decode_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // Write port: commit on the rising edge, never into register 0
    // NOTE: the array is reset because the pipeline relies on every register
    // reading zero after reset; this costs flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (ra == '0)
            return '0;
        else if (we && (wa == ra))
            return wd;
        else
            return regs[ra];
    endfunction

    // Read ports: hardwired zero, write-before-read bypass, then array
    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: rtl/i_decode.sv
// Instruction-decode stage.
// IF/ID latch -> register-file read, sign extension, main control ->
// ID/EX latch. stall holds IF/ID and turns the ID/EX control into a bubble;
// flush squashes IF/ID to a NOP and also bubbles ID/EX, overriding stall.
module i_decode
    import i_decode_pkg::*;
#(
    parameter int                ADDR_W    = 5,
    parameter logic [DATA_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic clk,
    input  logic rst_n,
    i_decode_if.slave bus
);

    // IF/ID latch
    logic [DATA_W-1:0] ifid_instr;
    logic [DATA_W-1:0] ifid_npc;

    // Decode signals
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sext;
    ctl_t              ctl_next;

    // ID/EX latch
    logic [DATA_W-1:0] idex_npc;
    logic [DATA_W-1:0] idex_rd1;
    logic [DATA_W-1:0] idex_rd2;
    logic [DATA_W-1:0] idex_sext;
    logic [4:0]        idex_rt;
    logic [4:0]        idex_rd;
    ctl_t              idex_ctl;

    // IF/ID: squash on flush, hold on stall, otherwise take fetch outputs
    // NOTE: state is updated with <= so every flop samples pre-edge values,
    // independent of the order the always blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr <= NOP_INSTR;
            ifid_npc   <= '0;
        end else if (bus.flush) begin
            ifid_instr <= NOP_INSTR;
            ifid_npc   <= '0;
        end else if (!bus.stall) begin
            ifid_instr <= bus.instr_in;
            ifid_npc   <= bus.npc_in;
        end
    end

    assign rs_addr = ifid_instr[21 +: ADDR_W];
    assign rt_addr = ifid_instr[16 +: ADDR_W];
    assign sext    = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

    i_decode_reg_file #(
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.wb_reg_write),
        .wa    (bus.wb_write_reg),
        .wd    (bus.wb_write_data),
        .ra1   (rs_addr),
        .ra2   (rt_addr),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Main control, replaced by a bubble whenever the stage is stalled or flushed
    // NOTE: ctl_next is assigned a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        ctl_next = '0;
        if (!bus.stall && !bus.flush)
            ctl_next = decode_ctl(ifid_instr[31:26]);
    end

    // ID/EX: data fields always load; only the control bundle is bubbled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_npc  <= '0;
            idex_rd1  <= '0;
            idex_rd2  <= '0;
            idex_sext <= '0;
            idex_rt   <= '0;
            idex_rd   <= '0;
            idex_ctl  <= '0;
        end else begin
            idex_npc  <= ifid_npc;
            idex_rd1  <= rd1;
            idex_rd2  <= rd2;
            idex_sext <= sext;
            idex_rt   <= ifid_instr[20:16];
            idex_rd   <= ifid_instr[15:11];
            idex_ctl  <= ctl_next;
        end
    end

    assign bus.npc_out  = idex_npc;
    assign bus.rd1_out  = idex_rd1;
    assign bus.rd2_out  = idex_rd2;
    assign bus.sext_out = idex_sext;
    assign bus.rt_out   = idex_rt;
    assign bus.rd_out   = idex_rd;
    assign bus.wb_ctl   = idex_ctl.wb;
    assign bus.m_ctl    = idex_ctl.m;
    assign bus.ex_ctl   = idex_ctl.ex;

endmodule
